// File: rtl/rf_pkg.sv
// Shared register-file definitions used by the writeback arbiter, regfile and decode.
// Holds the address/data widths, the PC index and the arbiter preference encoding.
package rf_pkg;
    localparam int AW   = 4;
    localparam int DW   = 32;
    localparam int NREG = 15;
    localparam logic [AW-1:0] PC_IDX = 4'd15;

    typedef enum logic {
        PREF_MEM = 1'b0,
        PREF_ALU = 1'b1
    } pref_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. req[0]/gnt[0] is the load source, req[1]/gnt[1] the ALU.
// The preference flips only when both sources compete, so a lone requester never steals a turn.
module rr_arb2
    import rf_pkg::*;
(
    input  logic       clk,
    input  logic       srst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    pref_t state_reg;
    pref_t state_next;

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg <= PREF_MEM;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (!srst && (&req)) begin
            state_next = (state_reg == PREF_MEM) ? PREF_ALU : PREF_MEM;
        end
    end

    // No grants during reset: a held request is simply taken once reset drops.
    always_comb begin
        gnt = 2'b00;
        if (!srst) begin
            if (&req) begin
                gnt = (state_reg == PREF_MEM) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end
endmodule

// File: rtl/rf_writeback_arbiter.sv
// Owns the register-file write port: arbitrates ALU/load writebacks, registers the write,
// and keeps the pending-write scoreboard that drives decode's read-after-write stall.
module rf_writeback_arbiter
    import rf_pkg::*;
(
    input  logic            CLK,
    input  logic            RST,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_addr,
    input  logic [DW-1:0]   alu_data,
    output logic            alu_ready,
    input  logic            mem_valid,
    input  logic [AW-1:0]   mem_addr,
    input  logic [DW-1:0]   mem_data,
    output logic            mem_ready,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_addr,
    input  logic [AW-1:0]   chk_a1,
    input  logic [AW-1:0]   chk_a2,
    output logic            stall,
    output logic [NREG-1:0] busy,
    output logic            WE3,
    output logic [AW-1:0]   A3,
    output logic [DW-1:0]   WD3,
    output logic            err
);
    localparam int NSLOT = 1 << AW;

    logic [1:0]       gnt;
    logic             xfer;
    logic [AW-1:0]    xfer_addr;
    logic [DW-1:0]    xfer_data;
    logic             xfer_write;
    logic             we_reg;
    logic [AW-1:0]    a3_reg;
    logic [DW-1:0]    wd3_reg;
    logic             err_reg;
    logic             err_next;
    logic             double_issue;
    logic [NREG-1:0]  busy_reg;
    logic [NREG-1:0]  busy_next;
    logic [NREG-1:0]  set_vec;
    logic [NREG-1:0]  clr_vec;
    logic [NSLOT-1:0] busy_pad;

    rr_arb2 u_arb (
        .clk  (CLK),
        .srst (RST),
        .req  ({alu_valid, mem_valid}),
        .gnt  (gnt)
    );

    assign mem_ready  = gnt[0];
    assign alu_ready  = gnt[1];
    assign xfer       = |gnt;
    assign xfer_addr  = gnt[0] ? mem_addr : alu_addr;
    assign xfer_data  = gnt[0] ? mem_data : alu_data;
    assign xfer_write = xfer && (xfer_addr != PC_IDX);

    // Padded so any 4-bit address (including the PC) indexes safely; the PC slot reads 0.
    assign busy_pad = {{(NSLOT - NREG){1'b0}}, busy_reg};

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_sb
            assign set_vec[gi]   = issue_valid && (issue_addr == AW'(gi));
            assign clr_vec[gi]   = we_reg && (a3_reg == AW'(gi));
            assign busy_next[gi] = set_vec[gi] | (busy_reg[gi] & ~clr_vec[gi]);
        end
    endgenerate

    // A re-issue to a register whose write commits this very cycle is legitimate.
    assign double_issue = issue_valid && (issue_addr != PC_IDX) && busy_pad[issue_addr]
                          && !(we_reg && (a3_reg == issue_addr));

    assign err_next = double_issue
                      || (xfer && ((xfer_addr == PC_IDX) || !busy_pad[xfer_addr]));

    always_ff @(posedge CLK) begin
        if (RST) begin
            we_reg   <= 1'b0;
            a3_reg   <= '0;
            wd3_reg  <= '0;
            err_reg  <= 1'b0;
            busy_reg <= '0;
        end else begin
            we_reg   <= xfer_write;
            err_reg  <= err_next;
            busy_reg <= busy_next;
            if (xfer_write) begin
                a3_reg  <= xfer_addr;
                wd3_reg <= xfer_data;
            end
        end
    end

    assign stall = ((chk_a1 != PC_IDX) && busy_pad[chk_a1])
                 | ((chk_a2 != PC_IDX) && busy_pad[chk_a2]);

    assign busy = busy_reg;
    assign WE3  = we_reg;
    assign A3   = a3_reg;
    assign WD3  = wd3_reg;
    assign err  = err_reg;
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Bench for rf_writeback_arbiter: directed scenarios with literal expectations, then random
// traffic compared every cycle against a behavioural model of the write port and scoreboard.
module tb_rf_writeback_arbiter;
    import rf_pkg::*;

    logic            CLK = 1'b0;
    logic            RST;
    logic            alu_valid, mem_valid, issue_valid;
    logic [AW-1:0]   alu_addr, mem_addr, issue_addr, chk_a1, chk_a2;
    logic [DW-1:0]   alu_data, mem_data;
    logic            alu_ready, mem_ready, stall, WE3, err;
    logic [NREG-1:0] busy;
    logic [AW-1:0]   A3;
    logic [DW-1:0]   WD3;

    always #5 CLK = ~CLK;

    rf_writeback_arbiter dut (
        .CLK(CLK), .RST(RST),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .chk_a1(chk_a1), .chk_a2(chk_a2), .stall(stall), .busy(busy),
        .WE3(WE3), .A3(A3), .WD3(WD3), .err(err)
    );

    int checks   = 0;
    int failures = 0;
    bit checking = 0;

    // Behavioural model: pending-write set, expected write port, and who goes first on a tie.
    bit          m_busy [16];
    bit          m_we;
    logic [3:0]  m_a3;
    logic [31:0] m_wd;
    bit          m_err;
    bit          mem_first = 1;
    bit          g_alu, g_mem;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [14:0] model_busy();
        logic [14:0] v;
        for (int i = 0; i < 15; i++) v[i] = m_busy[i];
        return v;
    endfunction

    // One clock: check combinational outputs, advance the model at the edge, check registers.
    task automatic tick();
        bit          ea, em, est, ne;
        bit          nb [16];
        logic [3:0]  wa;
        logic [31:0] wdat;
        #1;
        if (RST) begin
            ea = 0; em = 0;
        end else if (alu_valid && mem_valid) begin
            em = mem_first; ea = !mem_first;
        end else begin
            ea = alu_valid; em = mem_valid;
        end
        est = (chk_a1 != 15 && m_busy[chk_a1]) || (chk_a2 != 15 && m_busy[chk_a2]);
        if (checking) begin
            chk("alu_ready", alu_ready, ea);
            chk("mem_ready", mem_ready, em);
            chk("stall", stall, est);
        end
        g_alu = ea;
        g_mem = em;
        @(posedge CLK);
        if (RST) begin
            for (int i = 0; i < 16; i++) m_busy[i] = 0;
            m_we = 0; m_a3 = 0; m_wd = 0; m_err = 0; mem_first = 1;
        end else begin
            ne = 0;
            nb = m_busy;
            if (m_we) nb[m_a3] = 0;
            if (issue_valid && issue_addr != 15) begin
                if (m_busy[issue_addr] && !(m_we && m_a3 == issue_addr)) ne = 1;
                nb[issue_addr] = 1;
            end
            if (alu_valid && mem_valid) mem_first = !mem_first;
            if (ea || em) begin
                wa   = em ? mem_addr : alu_addr;
                wdat = em ? mem_data : alu_data;
                if (wa == 15) begin
                    m_we = 0; ne = 1;
                end else begin
                    if (!m_busy[wa]) ne = 1;
                    m_we = 1; m_a3 = wa; m_wd = wdat;
                end
            end else begin
                m_we = 0;
            end
            m_busy = nb;
            m_err  = ne;
        end
        @(negedge CLK);
        if (checking) begin
            chk("WE3", WE3, m_we);
            chk("busy", busy, model_busy());
            chk("err", err, m_err);
            if (m_we) begin
                chk("A3", A3, m_a3);
                chk("WD3", WD3, m_wd);
            end
        end
    endtask

    initial begin
        RST = 1;
        alu_valid = 1; alu_addr = 4'd1; alu_data = 32'd5;
        mem_valid = 1; mem_addr = 4'd2; mem_data = 32'd7;
        issue_valid = 0; issue_addr = 0; chk_a1 = 0; chk_a2 = 0;
        @(negedge CLK);
        tick();
        checking = 1;

        // Reset with both requesters holding valid
        #1;
        chk("t1_alu_ready", alu_ready, 0);
        chk("t1_mem_ready", mem_ready, 0);
        tick();
        chk("t1_we", WE3, 0);
        chk("t1_busy", busy, 0);

        // Contention: mem, alu, mem
        RST = 0;
        #1;
        chk("t2_mem_first", mem_ready, 1);
        chk("t2_alu_wait", alu_ready, 0);
        tick();
        chk("t2_we1", WE3, 1); chk("t2_a3_1", A3, 2); chk("t2_wd_1", WD3, 7);
        #1;
        chk("t2_alu_second", alu_ready, 1);
        tick();
        chk("t2_a3_2", A3, 1); chk("t2_wd_2", WD3, 5);
        #1;
        chk("t2_mem_third", mem_ready, 1);
        tick();
        chk("t2_a3_3", A3, 2);
        alu_valid = 0; mem_valid = 0;
        tick();
        chk("t2_idle_we", WE3, 0);

        // Scoreboard stall through commit
        issue_valid = 1; issue_addr = 4'd3;
        tick();
        issue_valid = 0; chk_a1 = 4'd3;
        #1;
        chk("t3_stall_pending", stall, 1);
        alu_valid = 1; alu_addr = 4'd3; alu_data = 32'h10;
        tick();
        alu_valid = 0;
        chk("t3_we", WE3, 1); chk("t3_a3", A3, 3); chk("t3_wd", WD3, 32'h10); chk("t3_err", err, 0);
        #1;
        chk("t3_stall_we_cycle", stall, 1);
        tick();
        #1;
        chk("t3_stall_cleared", stall, 0);
        chk_a1 = 0;

        // Same-cycle set and clear of r4
        issue_valid = 1; issue_addr = 4'd4;
        tick();
        issue_valid = 0;
        alu_valid = 1; alu_addr = 4'd4; alu_data = 32'h44;
        tick();
        alu_valid = 0; issue_valid = 1; issue_addr = 4'd4;
        tick();
        issue_valid = 0;
        chk("t4_busy4", busy[4], 1);
        chk("t4_err", err, 0);

        // Write to the PC slot
        mem_valid = 1; mem_addr = 4'd15; mem_data = 32'h99; chk_a1 = 4'd15; chk_a2 = 4'd15;
        #1;
        chk("t5_mem_ready", mem_ready, 1);
        chk("t5_pc_no_stall", stall, 0);
        tick();
        mem_valid = 0;
        chk("t5_we", WE3, 0);
        chk("t5_err", err, 1);
        tick();
        chk("t5_err_pulse", err, 0);

        // Double issue, then reset while stalled
        chk_a1 = 0; chk_a2 = 0;
        issue_valid = 1; issue_addr = 4'd5;
        tick();
        tick();
        issue_valid = 0;
        chk("t6_err", err, 1);
        chk("t6_busy5", busy[5], 1);
        chk_a1 = 4'd5;
        #1;
        chk("t6_stall", stall, 1);
        RST = 1;
        tick();
        RST = 0;
        chk("t6_busy_rst", busy, 0);
        #1;
        chk("t6_stall_rst", stall, 0);
        tick();

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            RST = ($urandom_range(149) == 0);
            if (!alu_valid && $urandom_range(1) == 1) begin
                alu_valid = 1; alu_addr = 4'($urandom_range(15)); alu_data = $urandom;
            end
            if (!mem_valid && $urandom_range(1) == 1) begin
                mem_valid = 1; mem_addr = 4'($urandom_range(15)); mem_data = $urandom;
            end
            issue_valid = ($urandom_range(2) == 0);
            issue_addr  = 4'($urandom_range(15));
            chk_a1      = 4'($urandom_range(15));
            chk_a2      = 4'($urandom_range(15));
            tick();
            if (g_alu) alu_valid = 0;
            if (g_mem) mem_valid = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
